mc_cpu_core_hs: RTL

//  Multi-cycle MIPS-subset core (32-bit datapath, unified inst/data memory) whose memory

---
 rtl/mc_cpu_core_hs_if.sv | 21 ++
 rtl/mc_cpu_core_hs.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mc_cpu_core_hs_if.sv
// Memory port of mc_cpu_core_hs: single outstanding req/ack transfer, read data valid with ack.
interface mc_cpu_core_hs_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mc_cpu_core_hs.sv
// Multi-cycle MIPS-subset core with a stalling req/ack memory port and sticky traps
// for illegal opcodes, misaligned lw/sw and memory timeouts.
module mc_cpu_core_hs #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_W      = 32,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    mc_cpu_core_hs_if.master m_mem,
    output logic             o_retire,
    output logic [31:0]      o_pc,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [2:0]      r_state;
    logic [31:0]     r_pc, r_ipc, r_ir, r_a, r_b, r_alu, r_mdr;
    logic [31:0]     r_rf [0:31];
    logic            r_mem_req;
    logic [TO_W-1:0] r_to_cnt;
    logic [1:0]      r_cause;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_dest;
    logic [31:0] w_sext, w_alu, w_addr_full;
    logic        w_is_r, w_is_jr, w_is_mem, w_legal, w_ack, w_timeout;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_fn     = r_ir[5:0];
    assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_is_r   = (w_op == OP_R);
    assign w_is_jr  = w_is_r && (w_fn == FN_JR);
    assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_dest   = w_is_r ? w_rd : w_rt;

    assign w_legal = w_is_r ? (w_fn == FN_SLL || w_fn == FN_JR || w_fn == FN_ADDU ||
                               w_fn == FN_SUBU || w_fn == FN_AND || w_fn == FN_OR ||
                               w_fn == FN_SLT)
                            : (w_op == OP_J || w_op == OP_JAL || w_op == OP_BEQ ||
                               w_op == OP_ADDIU || w_op == OP_LUI || w_is_mem);

    // Acks are honoured only while a request is actually outstanding.
    assign w_ack     = r_mem_req && m_mem.mem_ack;
    assign w_timeout = (TIMEOUT_CYC != 0) && r_mem_req && !m_mem.mem_ack &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // NOTE: every output of always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_alu = r_a + w_sext;
        if (w_is_r) begin
            case (w_fn)
                FN_SUBU: w_alu = r_a - r_b;
                FN_AND:  w_alu = r_a & r_b;
                FN_OR:   w_alu = r_a | r_b;
                FN_SLT:  w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
                FN_SLL:  w_alu = r_b << r_ir[10:6];
                default: w_alu = r_a + r_b;
            endcase
        end else if (w_op == OP_LUI) begin
            w_alu = {r_ir[15:0], 16'h0000};
        end
    end

    function automatic logic [31:0] rf_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : r_rf[idx];
    endfunction

    // NOTE: the register file is reset explicitly because software may rely on r1..r31 = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ipc     <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_mem_req <= 1'b0;
            r_to_cnt  <= '0;
            r_cause   <= 2'd0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_to_cnt <= (r_mem_req && !m_mem.mem_ack) ? r_to_cnt + TO_W'(1) : '0;
            case (r_state)
                S_FETCH: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (w_ack) begin
                        r_ir      <= m_mem.mem_rdata;
                        r_ipc     <= r_pc;
                        r_pc      <= r_pc + 32'd4;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end else if (w_timeout) begin
                        r_ipc     <= r_pc;
                        r_mem_req <= 1'b0;
                        r_cause   <= 2'd2;
                        r_state   <= S_TRAP;
                    end
                end
                S_DECODE: begin
                    r_a   <= rf_rd(w_rs);
                    r_b   <= rf_rd(w_rt);
                    r_alu <= r_pc + {w_sext[29:0], 2'b00};
                    if (!w_legal) begin
                        r_cause <= 2'd0;
                        r_state <= S_TRAP;
                    end else if (w_op == OP_J || w_op == OP_JAL) begin
                        r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        if (w_op == OP_JAL) r_rf[31] <= r_pc;
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_BEQ) begin
                        if (r_a == r_b) r_pc <= r_alu;
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_is_jr) begin
                        r_pc      <= r_a;
                        r_mem_req <= 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_is_mem) begin
                        r_alu <= w_alu;
                        if (w_alu[1:0] != 2'b00) begin
                            r_cause <= 2'd1;
                            r_state <= S_TRAP;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= S_MEM;
                        end
                    end else begin
                        r_alu   <= w_alu;
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        if (w_op == OP_LW) begin
                            r_mdr   <= m_mem.mem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_cause   <= 2'd2;
                        r_state   <= S_TRAP;
                    end
                end
                S_WB: begin
                    if (w_dest != 5'd0) r_rf[w_dest] <= (w_op == OP_LW) ? r_mdr : r_alu;
                    r_mem_req <= 1'b1;
                    r_state   <= S_FETCH;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Bits [1:0] are forced low so a misaligned jr target can never reach the bus.
    assign w_addr_full     = (r_state == S_MEM) ? r_alu : r_pc;
    assign m_mem.mem_req   = r_mem_req;
    assign m_mem.mem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign m_mem.mem_addr  = {w_addr_full[ADDR_W-1:2], 2'b00};
    assign m_mem.mem_wdata = r_b;

    assign o_retire = (r_state == S_WB) ||
                      (r_state == S_DECODE && (w_op == OP_J || w_op == OP_JAL)) ||
                      (r_state == S_EXEC && (w_op == OP_BEQ || w_is_jr)) ||
                      (r_state == S_MEM && w_ack && w_op == OP_SW);
    assign o_pc         = (r_state == S_FETCH) ? r_pc : r_ipc;
    assign o_trap       = (r_state == S_TRAP);
    assign o_trap_cause = r_cause;
endmodule
